// File: rtl/mem_resp_pipe_pkg.sv
// Shared memory types: word width, latency bounds and request/response bundles.
// Combinational helpers only; no state lives here.
package mem_resp_pipe_pkg;

  localparam int WORD_W      = 16;
  localparam int DEF_LATENCY = 4;
  localparam int MAX_LATENCY = 8;

  typedef struct packed {
    logic              enable;
    logic              wr;
    logic [15:0]       addr;
    logic [WORD_W-1:0] data;
  } mem_req_t;

  typedef struct packed {
    logic              data_valid;
    logic [WORD_W-1:0] data;
  } mem_rsp_t;

  // Response data is forced to zero whenever it is not valid.
  function automatic logic [WORD_W-1:0] mask_word(input logic vld, input logic [WORD_W-1:0] dat);
    return vld ? dat : '0;
  endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Read return pipeline: LATENCY-stage valid+data shift register, synchronous clear.
// Latency LATENCY cycles from capture to data_valid; no backpressure, advances every cycle.
module mem_rd_pipe
  import mem_resp_pipe_pkg::*;
#(
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic              clk,
  input  logic              rst,
  input  mem_rsp_t          rd_rsp,
  output logic              data_valid,
  output logic [WORD_W-1:0] data_out,
  output logic              busy
);

  logic [LATENCY-1:0]             vld_q, vld_d;
  logic [LATENCY-1:0][WORD_W-1:0] dat_q, dat_d;

  always_comb begin
    vld_d    = vld_q;
    dat_d    = dat_q;
    vld_d[0] = rd_rsp.data_valid;
    // Masking at entry keeps every invalid stage at zero, so the output needs no mux.
    dat_d[0] = mask_word(rd_rsp.data_valid, rd_rsp.data);
    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign data_valid = vld_q[LATENCY-1];
  assign data_out   = dat_q[LATENCY-1];
  assign busy       = |vld_q;

endmodule

// File: rtl/mem_resp_pipe.sv
// Pipelined single-port memory responder: writes commit at once, reads return after LATENCY cycles.
// Accepts a request every cycle; no backpressure, up to LATENCY reads in flight.
module mem_resp_pipe
  import mem_resp_pipe_pkg::*;
#(
  parameter int    LATENCY   = DEF_LATENCY,
  parameter int    ADDR_W    = 16,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [15:0]       addr,
  input  logic              wr,
  input  logic [WORD_W-1:0] data_in,
  output logic              data_valid,
  output logic [WORD_W-1:0] data_out,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;

  mem_req_t          req_d;
  mem_rsp_t          rd_rsp_d;
  logic [16:0]       addr_ext_d;
  logic [ADDR_W-1:0] idx_d;
  logic              wr_en_d;
  logic [WORD_W-1:0] mem_q [DEPTH];

  always_comb begin
    req_d = '{enable: enable, wr: wr, addr: addr, data: data_in};
    // Byte address to word index; bits above ADDR_W drop out so addresses alias.
    addr_ext_d = {1'b0, req_d.addr};
    idx_d      = ADDR_W'(addr_ext_d >> 1);
    // Requests arriving in a reset cycle are discarded, writes included.
    wr_en_d             = req_d.enable & req_d.wr & ~rst;
    rd_rsp_d.data_valid = req_d.enable & ~req_d.wr & ~rst;
    rd_rsp_d.data       = mem_q[idx_d];
  end

  always_ff @(posedge clk) begin
    if (wr_en_d) begin
      mem_q[idx_d] <= req_d.data;
    end
  end

  mem_rd_pipe #(
    .LATENCY (LATENCY)
  ) u_rd_pipe (
    .clk        (clk),
    .rst        (rst),
    .rd_rsp     (rd_rsp_d),
    .data_valid (data_valid),
    .data_out   (data_out),
    .busy       (busy)
  );

endmodule
